// File: rtl/microcode_sequencer_pkg.sv
// Purpose : shared constants and types for the microcode sequencer.
// Latency : n/a (types, constants and one pure helper function).
// Backpr. : n/a.
// Contents: control-word bit indices, FSM state encoding, default jump
//           opcodes, bus widths and the conditional-jump masking helper.
package microcode_sequencer_pkg;

  localparam int CTRL_W = 16;
  localparam int OPC_W  = 4;
  localparam int STEP_W = 4;
  localparam int ADDR_W = OPC_W + STEP_W;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  // Control-word bit positions.
  localparam int CB_HLT = 15;
  localparam int CB_MI  = 14;
  localparam int CB_RI  = 13;
  localparam int CB_RO  = 12;
  localparam int CB_IO  = 11;
  localparam int CB_II  = 10;
  localparam int CB_AI  = 9;
  localparam int CB_AO  = 8;
  localparam int CB_EO  = 7;
  localparam int CB_SU  = 6;
  localparam int CB_BI  = 5;
  localparam int CB_OI  = 4;
  localparam int CB_CE  = 3;
  localparam int CB_CO  = 2;
  localparam int CB_J   = 1;
  localparam int CB_FI  = 0;

  // Opcodes whose J bit is conditional on a flag.
  localparam logic [OPC_W-1:0] DEF_JC_OPCODE = 4'h7;
  localparam logic [OPC_W-1:0] DEF_JZ_OPCODE = 4'h8;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Clears the J bit of a control word when the jump condition fails.
  function automatic ctrl_word_t mask_jump(input ctrl_word_t word, input logic kill_j);
    ctrl_word_t res;
    res = word;
    if (kill_j) res[CB_J] = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// Purpose : bundles the sequencer's opcode/flag inputs, ROM port and control outputs.
// Latency : n/a (wiring only).
// Backpr. : clk_en is the only stall; it freezes the sequencer completely.
// Modports: master = sequencer side (drives rom_addr/ctrl/status),
//           slave  = environment side (drives clk_en, instr, flags, rom_data).
import microcode_sequencer_pkg::*;

interface microcode_sequencer_if;
  logic                clk_en;
  logic [OPC_W-1:0]    instr;
  logic                flag_carry;
  logic                flag_zero;
  ctrl_word_t          rom_data;
  logic [ADDR_W-1:0]   rom_addr;
  ctrl_word_t          ctrl;
  logic                ctrl_valid;
  logic [STEP_W-1:0]   step;
  logic                instr_done;
  logic                halted;

  modport master (
    input  clk_en, instr, flag_carry, flag_zero, rom_data,
    output rom_addr, ctrl, ctrl_valid, step, instr_done, halted
  );

  modport slave (
    output clk_en, instr, flag_carry, flag_zero, rom_data,
    input  rom_addr, ctrl, ctrl_valid, step, instr_done, halted
  );
endinterface

// File: rtl/microcode_sequencer_microstep_counter.sv
// Purpose : 4-bit microstep register with synchronous clear and increment.
// Latency : new value visible the cycle after the enabled edge.
// Backpr. : i_en=0 holds the count regardless of i_clr/i_inc.
// Ports   : i_clk, i_reset (sync, active-high), i_en, i_clr, i_inc -> o_step.
import microcode_sequencer_pkg::*;

module microstep_counter (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [STEP_W-1:0] o_step
);

  logic [STEP_W-1:0] r_step;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step <= '0;
    end else if (i_en) begin
      // Clear has priority so end-of-instruction never races an increment.
      if (i_clr)      r_step <= '0;
      else if (i_inc) r_step <= r_step + 1'b1;
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/microcode_sequencer.sv
// Purpose : microcode control unit; walks {instr, step} through the ROM, two clocks per microstep.
// Latency : ROM address in FETCH, control word out combinationally in the following EXEC cycle.
// Backpr. : clk_en=0 freezes state, step and outputs and suppresses instr_done.
// Ports   : i_clk, i_reset (sync, active-high), bus (master modport: instr/flags/rom_data in,
//           rom_addr/ctrl/ctrl_valid/step/instr_done/halted out).
import microcode_sequencer_pkg::*;

module microcode_sequencer #(
  parameter int               MAX_STEPS = 16,
  parameter logic [OPC_W-1:0] JC_OPCODE = DEF_JC_OPCODE,
  parameter logic [OPC_W-1:0] JZ_OPCODE = DEF_JZ_OPCODE
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  microcode_sequencer_if.master  bus
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [STEP_W-1:0] w_step;
  logic              w_clr;
  logic              w_inc;
  logic              w_kill_j;
  ctrl_word_t        w_word;
  ctrl_word_t        w_ctrl;
  logic              w_vld;
  logic              w_done;
  logic              w_halted;

  microstep_counter u_step (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (bus.clk_en),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_step  (w_step)
  );

  // A conditional jump whose flag is clear must not load the PC.
  assign w_kill_j = ((bus.instr == JC_OPCODE) && !bus.flag_carry) ||
                    ((bus.instr == JZ_OPCODE) && !bus.flag_zero);
  assign w_word   = mask_jump(bus.rom_data, w_kill_j);

  always_ff @(posedge i_clk) begin
    if (i_reset)         r_state <= ST_FETCH;
    else if (bus.clk_en) r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ctrl   = '0;
    w_vld    = 1'b0;
    w_done   = 1'b0;
    w_clr    = 1'b0;
    w_inc    = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        // The end-of-instruction test looks at the raw word, so a JC/JZ
        // step masked down to zero still runs on to the next step.
        if (bus.rom_data == '0) begin
          w_done = 1'b1;
          w_clr  = 1'b1;
          w_next = ST_FETCH;
        end else if (bus.rom_data[CB_HLT]) begin
          w_ctrl = w_word;
          w_vld  = 1'b1;
          w_next = ST_HALT;
        end else if (w_step == STEP_LAST) begin
          w_ctrl = w_word;
          w_vld  = 1'b1;
          w_done = 1'b1;
          w_clr  = 1'b1;
          w_next = ST_FETCH;
        end else begin
          w_ctrl = w_word;
          w_vld  = 1'b1;
          w_inc  = 1'b1;
          w_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  // Address is purely {instr, step}; an II load at the end of EXEC is
  // therefore seen by the very next FETCH.
  assign bus.rom_addr   = {bus.instr, w_step};
  assign bus.ctrl       = w_ctrl;
  assign bus.ctrl_valid = w_vld;
  assign bus.step       = w_step;
  assign bus.instr_done = w_done & bus.clk_en;
  assign bus.halted     = w_halted;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

  logic clk = 1'b0;
  logic reset1;
  logic reset2;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  microcode_sequencer_if bus1();
  microcode_sequencer_if bus2();

  microcode_sequencer #(.MAX_STEPS(16)) dut1 (
    .i_clk   (clk),
    .i_reset (reset1),
    .bus     (bus1.master)
  );

  microcode_sequencer #(.MAX_STEPS(6)) dut2 (
    .i_clk   (clk),
    .i_reset (reset2),
    .bus     (bus2.master)
  );

  // Registered ROM models: data valid one cycle after the address.
  logic [15:0] rom [256];
  logic [15:0] rom_q1 = 16'h0;
  logic [15:0] rom_q2 = 16'h0;
  always @(posedge clk) begin
    rom_q1 <= rom[bus1.rom_addr];
    rom_q2 <= rom[bus2.rom_addr];
  end
  assign bus1.rom_data = rom_q1;
  assign bus2.rom_data = rom_q2;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  instr;
    logic [7:0]  addr;
    logic [15:0] ctrl;
    logic        vld;
    logic [3:0]  step;
    logic        done;
    logic        halt;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart1(input logic [3:0] op);
    bus1.instr = op;
    reset1 = 1'b1;
    cyc(1);
    reset1 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    // LDA
    rom[8'h10] = 16'h4004; rom[8'h11] = 16'h1408; rom[8'h12] = 16'h4800;
    rom[8'h13] = 16'h1200; rom[8'h14] = 16'h0000;
    // JC: step3 word only has J, so masking can zero it
    rom[8'h70] = 16'h0004; rom[8'h71] = 16'h0004; rom[8'h72] = 16'h0802;
    rom[8'h73] = 16'h0002; rom[8'h74] = 16'h0000;
    // JZ
    rom[8'h80] = 16'h0004; rom[8'h81] = 16'h0004; rom[8'h82] = 16'h0802;
    rom[8'h83] = 16'h0000;
    // HLT
    rom[8'hF0] = 16'h0004; rom[8'hF1] = 16'h0004; rom[8'hF2] = 16'h8000;
    // six-step opcode for the MAX_STEPS=6 instance
    for (int k = 0; k < 6; k++) rom[8'h20 + k] = 16'h0110 + 16'(k);

    reset1 = 1'b1; reset2 = 1'b1;
    bus1.clk_en = 1'b1; bus1.instr = 4'h1; bus1.flag_carry = 1'b0; bus1.flag_zero = 1'b0;
    bus2.clk_en = 1'b1; bus2.instr = 4'h2; bus2.flag_carry = 1'b0; bus2.flag_zero = 1'b0;
    cyc(1);

    // rst en instr addr  ctrl     vld step done halt
    vt[0]  = '{1'b1, 1'b1, 4'h1, 8'h10, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 4'h1, 8'h10, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 4'h1, 8'h10, 16'h4004, 1'b1, 4'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 4'h1, 8'h11, 16'h0000, 1'b0, 4'd1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 4'h1, 8'h11, 16'h1408, 1'b1, 4'd1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 4'h1, 8'h12, 16'h0000, 1'b0, 4'd2, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 4'h1, 8'h12, 16'h4800, 1'b1, 4'd2, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 4'h1, 8'h13, 16'h0000, 1'b0, 4'd3, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 4'h1, 8'h13, 16'h1200, 1'b1, 4'd3, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 4'h1, 8'h14, 16'h0000, 1'b0, 4'd4, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 4'h1, 8'h14, 16'h0000, 1'b0, 4'd4, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 4'h1, 8'h10, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      reset1 = vt[i].rst;
      bus1.clk_en = vt[i].en;
      bus1.instr = vt[i].instr;
      #1;
      chk($sformatf("lda[%0d].rom_addr", i), 32'(bus1.rom_addr), 32'(vt[i].addr));
      chk($sformatf("lda[%0d].ctrl", i), 32'(bus1.ctrl), 32'(vt[i].ctrl));
      chk($sformatf("lda[%0d].ctrl_valid", i), 32'(bus1.ctrl_valid), 32'(vt[i].vld));
      chk($sformatf("lda[%0d].step", i), 32'(bus1.step), 32'(vt[i].step));
      chk($sformatf("lda[%0d].instr_done", i), 32'(bus1.instr_done), 32'(vt[i].done));
      chk($sformatf("lda[%0d].halted", i), 32'(bus1.halted), 32'(vt[i].halt));
      cyc(1);
    end

    // JC: EXEC of step 2 is five cycles after the reset cycle.
    restart1(4'h7);
    cyc(5);
    bus1.flag_carry = 1'b0; #1;
    chk("jc_nc.ctrl", 32'(bus1.ctrl), 32'h0800);
    bus1.flag_carry = 1'b1; #1;
    chk("jc_c.ctrl", 32'(bus1.ctrl), 32'h0802);
    chk("jc_c.valid", 32'(bus1.ctrl_valid), 32'h1);
    // Step 3 word is J alone; masked to zero it must not end the instruction.
    bus1.flag_carry = 1'b0;
    cyc(2);
    chk("jc_zeroed.ctrl", 32'(bus1.ctrl), 32'h0000);
    chk("jc_zeroed.valid", 32'(bus1.ctrl_valid), 32'h1);
    chk("jc_zeroed.done", 32'(bus1.instr_done), 32'h0);
    cyc(1);
    chk("jc_zeroed.next_step", 32'(bus1.step), 32'd4);

    // JZ
    restart1(4'h8);
    cyc(5);
    bus1.flag_carry = 1'b1;
    bus1.flag_zero = 1'b0; #1;
    chk("jz_nz.ctrl", 32'(bus1.ctrl), 32'h0800);
    bus1.flag_zero = 1'b1; #1;
    chk("jz_z.ctrl", 32'(bus1.ctrl), 32'h0802);
    bus1.flag_carry = 1'b0; bus1.flag_zero = 1'b0;

    // HLT
    restart1(4'hF);
    cyc(5);
    chk("hlt.ctrl", 32'(bus1.ctrl), 32'h8000);
    chk("hlt.valid", 32'(bus1.ctrl_valid), 32'h1);
    chk("hlt.halted_pre", 32'(bus1.halted), 32'h0);
    cyc(1);
    for (int h = 0; h < 20; h++) begin
      chk($sformatf("halt[%0d].halted", h), 32'(bus1.halted), 32'h1);
      chk($sformatf("halt[%0d].ctrl", h), 32'(bus1.ctrl), 32'h0);
      chk($sformatf("halt[%0d].step", h), 32'(bus1.step), 32'd2);
      cyc(1);
    end
    reset1 = 1'b1;
    cyc(1);
    reset1 = 1'b0;
    chk("hlt_reset.step", 32'(bus1.step), 32'd0);
    chk("hlt_reset.halted", 32'(bus1.halted), 32'h0);

    // clk_en freeze during EXEC of step 3
    restart1(4'h1);
    cyc(7);
    bus1.clk_en = 1'b0;
    for (int f = 0; f < 5; f++) begin
      #1;
      chk($sformatf("hold[%0d].step", f), 32'(bus1.step), 32'd3);
      chk($sformatf("hold[%0d].ctrl", f), 32'(bus1.ctrl), 32'h1200);
      chk($sformatf("hold[%0d].rom_addr", f), 32'(bus1.rom_addr), 32'h13);
      chk($sformatf("hold[%0d].done", f), 32'(bus1.instr_done), 32'h0);
      cyc(1);
    end
    bus1.clk_en = 1'b1;
    cyc(1);
    chk("resume.step", 32'(bus1.step), 32'd4);
    chk("resume.rom_addr", 32'(bus1.rom_addr), 32'h14);
    cyc(1);
    chk("resume.done", 32'(bus1.instr_done), 32'h1);

    // reset in the middle of EXEC of step 3
    restart1(4'h1);
    cyc(7);
    chk("mid_reset.pre_ctrl", 32'(bus1.ctrl), 32'h1200);
    reset1 = 1'b1;
    cyc(1);
    reset1 = 1'b0;
    chk("mid_reset.ctrl", 32'(bus1.ctrl), 32'h0);
    chk("mid_reset.valid", 32'(bus1.ctrl_valid), 32'h0);
    chk("mid_reset.step", 32'(bus1.step), 32'd0);
    chk("mid_reset.rom_addr", 32'(bus1.rom_addr), 32'h10);

    // MAX_STEPS=6 instance: wraps after step 5 with instr_done.
    reset2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("wrap[%0d].fetch_step", k), 32'(bus2.step), 32'(k));
      chk($sformatf("wrap[%0d].rom_addr", k), 32'(bus2.rom_addr), 32'h20 + 32'(k));
      cyc(1);
      chk($sformatf("wrap[%0d].ctrl", k), 32'(bus2.ctrl), 32'h0110 + 32'(k));
      chk($sformatf("wrap[%0d].done", k), 32'(bus2.instr_done), (k == 5) ? 32'h1 : 32'h0);
      cyc(1);
    end
    chk("wrap.step0", 32'(bus2.step), 32'd0);
    chk("wrap.addr0", 32'(bus2.rom_addr), 32'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
